// File: rtl/niox_dma.sv
// niox_dma: single-word bus initiator that copies or fills a block of 32-bit words,
// using the niox sel/we/be/ack handshake with a per-strobe ack timeout.
module niox_dma #(
   parameter int unsigned LEN_W   = 12,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             fill_i,
   input  logic [31:0]      src_i,
   input  logic [31:0]      dst_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [31:0]      fill_data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] remain_o,
   output logic [31:0]      addr_o,
   output logic [31:0]      data_o,
   input  logic [31:0]      data_i,
   output logic [3:0]       be_o,
   output logic             we_o,
   output logic             sel_o,
   input  logic             ack_i
);

   localparam int unsigned   TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_RGAP = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_WGAP = 3'd4;
   localparam logic [2:0] ST_FIN  = 3'd5;

   logic [2:0]       r_state, w_state_d;
   logic [31:0]      r_src, w_src_d;
   logic [31:0]      r_dst, w_dst_d;
   logic [LEN_W-1:0] r_remain, w_remain_d;
   logic             r_fill, w_fill_d;
   logic [31:0]      r_buf, w_buf_d;
   logic             r_err, w_err_d;
   logic [TW-1:0]    r_tmo, w_tmo_d;

   // Word alignment is forced by masking, so the low address bits carry no information.
   logic w_unused_addr_lsbs;
   assign w_unused_addr_lsbs = ^{src_i[1:0], dst_i[1:0]};

   always_comb begin
      w_state_d  = r_state;
      w_src_d    = r_src;
      w_dst_d    = r_dst;
      w_remain_d = r_remain;
      w_fill_d   = r_fill;
      w_buf_d    = r_buf;
      w_err_d    = r_err;
      w_tmo_d    = r_tmo;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_src_d    = {src_i[31:2], 2'b00};
               w_dst_d    = {dst_i[31:2], 2'b00};
               w_remain_d = len_i;
               w_fill_d   = fill_i;
               w_buf_d    = fill_data_i;
               w_err_d    = 1'b0;
               w_tmo_d    = '0;
               if (len_i == '0) begin
                  w_state_d = ST_FIN;
               end else if (fill_i) begin
                  w_state_d = ST_WR;
               end else begin
                  w_state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (ack_i) begin
               w_buf_d   = data_i;
               w_state_d = ST_RGAP;
            end else if (r_tmo == TMO_LAST) begin
               w_err_d   = 1'b1;
               w_state_d = ST_FIN;
            end else begin
               w_tmo_d = r_tmo + TW'(1);
            end
         end
         ST_RGAP: begin
            w_tmo_d   = '0;
            w_state_d = ST_WR;
         end
         ST_WR: begin
            if (ack_i) begin
               w_state_d = ST_WGAP;
            end else if (r_tmo == TMO_LAST) begin
               w_err_d   = 1'b1;
               w_state_d = ST_FIN;
            end else begin
               w_tmo_d = r_tmo + TW'(1);
            end
         end
         ST_WGAP: begin
            w_tmo_d    = '0;
            w_dst_d    = r_dst + 32'd4;
            w_remain_d = r_remain - LEN_W'(1);
            if (!r_fill) begin
               w_src_d = r_src + 32'd4;
            end
            if (r_remain == LEN_W'(1)) begin
               w_state_d = ST_FIN;
            end else if (r_fill) begin
               w_state_d = ST_WR;
            end else begin
               w_state_d = ST_RD;
            end
         end
         ST_FIN: begin
            w_state_d = ST_IDLE;
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_remain <= '0;
         r_fill   <= 1'b0;
         r_buf    <= '0;
         r_err    <= 1'b0;
         r_tmo    <= '0;
      end else begin
         r_state  <= w_state_d;
         r_src    <= w_src_d;
         r_dst    <= w_dst_d;
         r_remain <= w_remain_d;
         r_fill   <= w_fill_d;
         r_buf    <= w_buf_d;
         r_err    <= w_err_d;
         r_tmo    <= w_tmo_d;
      end
   end

   // Bus outputs decode straight from state so an async reset drops strobes at once.
   assign sel_o    = (r_state == ST_RD);
   assign we_o     = (r_state == ST_WR);
   assign be_o     = (r_state == ST_RD || r_state == ST_WR) ? 4'hF : 4'h0;
   assign addr_o   = (r_state == ST_RD) ? r_src : ((r_state == ST_WR) ? r_dst : 32'h0);
   assign data_o   = (r_state == ST_WR) ? r_buf : 32'h0;
   assign busy_o   = (r_state != ST_IDLE);
   assign done_o   = (r_state == ST_FIN);
   assign err_o    = r_err;
   assign remain_o = r_remain;

endmodule

// File: tb/tb_niox_dma.sv
// Directed bench for niox_dma: RAM-like slave with programmable ack delay plus a bus
// monitor for strobe stability, idle gaps and byte enables.
module tb_niox_dma;
   localparam int unsigned LEN_W   = 12;
   localparam int unsigned TIMEOUT = 8;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic             fill_i = 1'b0;
   logic [31:0]      src_i = '0;
   logic [31:0]      dst_i = '0;
   logic [LEN_W-1:0] len_i = '0;
   logic [31:0]      fill_data_i = '0;
   logic             busy_o, done_o, err_o;
   logic [LEN_W-1:0] remain_o;
   logic [31:0]      addr_o, data_o, data_i;
   logic [3:0]       be_o;
   logic             we_o, sel_o, ack_i;

   int n_checks = 0;
   int n_fail   = 0;

   niox_dma #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .fill_i      (fill_i),
      .src_i       (src_i),
      .dst_i       (dst_i),
      .len_i       (len_i),
      .fill_data_i (fill_data_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .remain_o    (remain_o),
      .addr_o      (addr_o),
      .data_o      (data_o),
      .data_i      (data_i),
      .be_o        (be_o),
      .we_o        (we_o),
      .sel_o       (sel_o),
      .ack_i       (ack_i)
   );

   always #5 clk_i = ~clk_i;

   // Source words: 0x100..0x10C hold 11111111..44444444, elsewhere an address hash.
   function automatic logic [31:0] src_word(input logic [31:0] a);
      if (a >= 32'h100 && a <= 32'h10C) return ((a - 32'h100) / 4 + 1) * 32'h11111111;
      return a ^ 32'hA5A5A5A5;
   endfunction

   // Slave: acks ack_delay cycles after a strobe appears (0 = never), ack toggles off after.
   logic [31:0] mem [0:1023];
   logic [31:0] wr_log [0:15];
   int ack_delay = 1;
   int wcnt = 0, rd_cnt = 0, wr_cnt = 0;
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_i  <= 1'b0;
         data_i <= '0;
         wcnt   <= 0;
      end else if ((sel_o || we_o) && !ack_i) begin
         if (ack_delay != 0 && wcnt + 1 >= ack_delay) begin
            ack_i <= 1'b1;
            wcnt  <= 0;
            if (we_o) begin
               mem[addr_o[11:2]]  <= data_o;
               wr_log[wr_cnt % 16] <= addr_o;
               wr_cnt             <= wr_cnt + 1;
            end else begin
               data_i <= src_word(addr_o);
               rd_cnt <= rd_cnt + 1;
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         ack_i <= 1'b0;
         wcnt  <= 0;
      end
   end

   int done_cnt = 0, str_cnt = 0, sel_cnt = 0, bad_cnt = 0;
   logic p_str = 1'b0, p_ack = 1'b0;
   logic [31:0] p_addr = '0, p_data = '0;
   always @(negedge clk_i) begin
      if (sel_o) sel_cnt <= sel_cnt + 1;
      if (sel_o || we_o) str_cnt <= str_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if ((sel_o && we_o) ||
          ((sel_o || we_o) && p_str && !p_ack && (addr_o !== p_addr || data_o !== p_data)) ||
          ((sel_o || we_o) && p_str && p_ack) ||
          (be_o !== ((sel_o || we_o) ? 4'hF : 4'h0)))
         bad_cnt <= bad_cnt + 1;
      p_str  <= sel_o || we_o;
      p_ack  <= ack_i;
      p_addr <= addr_o;
      p_data <= data_o;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic kick(input logic f, input logic [31:0] s, input logic [31:0] d,
                       input logic [LEN_W-1:0] n, input logic [31:0] pat);
      step();
      start_i = 1'b1; fill_i = f; src_i = s; dst_i = d; len_i = n; fill_data_i = pat;
      step();
      start_i = 1'b0; fill_i = 1'b0;
   endtask

   // Returns the cycle index (1 = cycle right after the start edge) at which done_o is seen.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done_o && cyc < 400) begin
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({busy_o, done_o, err_o, remain_o, addr_o, data_o, be_o, we_o, sel_o} !== '0) begin
         n_fail++; $display("FAIL reset_in: outputs=%h required 0",
            {busy_o, done_o, err_o, remain_o, addr_o, data_o, be_o, we_o, sel_o});
      end
      step(); step();
      rst_i = 1'b0;
      step();
      n_checks++;
      if ({busy_o, done_o, err_o, remain_o, we_o, sel_o} !== '0) begin
         n_fail++; $display("FAIL reset_out: outputs=%h required 0",
            {busy_o, done_o, err_o, remain_o, we_o, sel_o});
      end
   endtask

   task automatic test_copy();
      int cyc, d0, r0, w0, b0;
      ack_delay = 1;
      d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt; b0 = bad_cnt;
      kick(1'b0, 32'h100, 32'h200, 12'd4, 32'h0);
      n_checks++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL copy_busy: got %b required 1", busy_o); end
      wait_done(cyc);
      n_checks++;
      if (cyc !== 25) begin n_fail++; $display("FAIL copy_cycles: got %0d required 25", cyc); end
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (mem[128 + i] !== (i + 1) * 32'h11111111) begin
            n_fail++; $display("FAIL copy_word%0d: got %h required %h", i, mem[128 + i],
                               (i + 1) * 32'h11111111);
         end
      end
      n_checks++;
      if (err_o !== 1'b0 || remain_o !== 12'd0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL copy_status: err=%b remain=%0d busy=%b required 0/0/0",
                            err_o, remain_o, busy_o);
      end
      n_checks++;
      if (done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL copy_done: pulses=%0d required 1", done_cnt - d0);
      end
      n_checks++;
      if (rd_cnt - r0 !== 4 || wr_cnt - w0 !== 4 || bad_cnt !== b0) begin
         n_fail++; $display("FAIL copy_bus: reads=%0d writes=%0d protocol_errs=%0d required 4/4/0",
                            rd_cnt - r0, wr_cnt - w0, bad_cnt - b0);
      end
   endtask

   task automatic test_fill();
      int cyc, d0, r0, w0;
      ack_delay = 1;
      d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
      kick(1'b1, 32'h0, 32'h300, 12'd3, 32'hDEADBEEF);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 10) begin n_fail++; $display("FAIL fill_cycles: got %0d required 10", cyc); end
      step();
      n_checks++;
      if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 3) begin
         n_fail++; $display("FAIL fill_bus: reads=%0d writes=%0d required 0/3",
                            rd_cnt - r0, wr_cnt - w0);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (mem[192 + i] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL fill_word%0d: got %h required DEADBEEF", i, mem[192 + i]);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL fill_done: pulses=%0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_zero_len();
      int cyc, s0;
      s0 = str_cnt;
      kick(1'b0, 32'h100, 32'h200, 12'd0, 32'h0);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL zero_cycles: got %0d required 1", cyc); end
      step(); step();
      n_checks++;
      if (str_cnt - s0 !== 0) begin
         n_fail++; $display("FAIL zero_strobes: strobe cycles=%0d required 0", str_cnt - s0);
      end
   endtask

   task automatic test_timeout();
      int cyc, s0, w0;
      ack_delay = 0;
      s0 = sel_cnt; w0 = wr_cnt;
      kick(1'b0, 32'h100, 32'h200, 12'd2, 32'h0);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 9) begin n_fail++; $display("FAIL tmo_cycles: got %0d required 9", cyc); end
      n_checks++;
      if (sel_o !== 1'b0 || err_o !== 1'b1 || remain_o !== 12'd2) begin
         n_fail++; $display("FAIL tmo_fin: sel=%b err=%b remain=%0d required 0/1/2",
                            sel_o, err_o, remain_o);
      end
      step();
      n_checks++;
      if (sel_cnt - s0 !== 8 || wr_cnt - w0 !== 0) begin
         n_fail++; $display("FAIL tmo_sel: sel cycles=%0d writes=%0d required 8/0",
                            sel_cnt - s0, wr_cnt - w0);
      end
      n_checks++;
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: err=%b required 1", err_o); end
      ack_delay = 1;
      kick(1'b0, 32'h100, 32'h200, 12'd0, 32'h0);
      n_checks++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: err=%b required 0", err_o); end
      step();
   endtask

   task automatic test_wrap_stall();
      int cyc, w0, b0;
      ack_delay = 3;
      w0 = wr_cnt; b0 = bad_cnt;
      kick(1'b1, 32'h0, 32'hFFFFFFFC, 12'd2, 32'hA5A55A5A);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 11) begin n_fail++; $display("FAIL wrap_cycles: got %0d required 11", cyc); end
      step();
      n_checks++;
      if (wr_cnt - w0 !== 2 || wr_log[w0 % 16] !== 32'hFFFFFFFC ||
          wr_log[(w0 + 1) % 16] !== 32'h0) begin
         n_fail++; $display("FAIL wrap_addr: writes=%0d first=%h second=%h required 2/FFFFFFFC/0",
                            wr_cnt - w0, wr_log[w0 % 16], wr_log[(w0 + 1) % 16]);
      end
      n_checks++;
      if (mem[1023] !== 32'hA5A55A5A || mem[0] !== 32'hA5A55A5A) begin
         n_fail++; $display("FAIL wrap_data: top=%h zero=%h required A5A55A5A", mem[1023], mem[0]);
      end
      n_checks++;
      if (bad_cnt !== b0) begin
         n_fail++; $display("FAIL wrap_protocol: errors=%0d required 0", bad_cnt - b0);
      end
      ack_delay = 1;
   endtask

   task automatic test_reset_mid();
      int k, cyc, d0, w0;
      ack_delay = 1;
      d0 = done_cnt; w0 = wr_cnt;
      kick(1'b0, 32'h100, 32'h400, 12'd4, 32'h0);
      k = 0;
      while (!(we_o && addr_o == 32'h404) && k < 40) begin
         step();
         k++;
      end
      n_checks++;
      if (k >= 40) begin n_fail++; $display("FAIL rst_reach: word2 write not seen in %0d cycles", k); end
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: we=%b required 0", we_o); end
      n_checks++;
      if ({busy_o, done_o, err_o, remain_o, addr_o, data_o, be_o, we_o, sel_o} !== '0) begin
         n_fail++; $display("FAIL rst_outputs: outputs=%h required 0",
            {busy_o, done_o, err_o, remain_o, addr_o, data_o, be_o, we_o, sel_o});
      end
      step(); step();
      rst_i = 1'b0;
      step(); step(); step();
      n_checks++;
      if (done_cnt - d0 !== 0 || wr_cnt - w0 !== 1) begin
         n_fail++; $display("FAIL rst_nodone: done pulses=%0d writes=%0d required 0/1",
                            done_cnt - d0, wr_cnt - w0);
      end
      kick(1'b0, 32'h100, 32'h500, 12'd1, 32'h0);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 7) begin n_fail++; $display("FAIL restart_cycles: got %0d required 7", cyc); end
      step();
      n_checks++;
      if (mem[320] !== 32'h11111111 || err_o !== 1'b0) begin
         n_fail++; $display("FAIL restart_data: word=%h err=%b required 11111111/0", mem[320], err_o);
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_fill();
      test_zero_len();
      test_timeout();
      test_wrap_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
